pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Reading end of a pipeline stage register: the consumer side that drains a write-enabled stage register under downstream backpressure.
- Sits between two datapath stages (e.g. ID->EX) and replaces plain write-enable gating with a valid/ready handshake.
- Uses a 2-entry skid buffer, so upstream in_ready is a registered signal and never combinationally depends on out_ready.
- Synchronous flush supports branch squash.

Parameters:
- reg_size, 32, data width in bits of the stage payload.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- flush  input  1  synchronous squash; empties both entries.
- in_valid  input  1  upstream has a payload on in_data.
- in_ready  output  1  block can accept a payload this cycle; registered.
- in_data  input  reg_size  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream consumes the payload this cycle.
- out_data  output  reg_size  head payload; registered, no combinational path from in_data.

Behaviour:
- Storage is main_q (head, drives out_data) and skid_q, plus valid bits main_v and skid_v.
- States, derived from the valid bits:
  - EMPTY: main_v=0, skid_v=0.
  - ONE: main_v=1, skid_v=0.
  - TWO: main_v=1, skid_v=1.
- Outputs: out_valid=main_v; in_ready=!skid_v (registered bit, 1 in EMPTY and ONE).
- A push occurs when in_valid & in_ready. A pop occurs when out_valid & out_ready.
- EMPTY:
  - push: main_q<=in_data, go to ONE.
  - No push: stay in EMPTY.
- ONE:
  - push & pop: main_q<=in_data, stay in ONE.
  - push only: skid_q<=in_data, go to TWO.
  - pop only: go to EMPTY.
  - Neither: hold.
- TWO:
  - Push is impossible because in_ready=0.
  - pop: main_q<=skid_q, go to ONE.
  - No pop: hold.
- Latency:
  - Data pushed in cycle N appears on out_data with out_valid=1 in cycle N+1 when the block was EMPTY.
  - Ordering is strictly FIFO.
- flush:
  - Has priority over push and pop.
  - Next state is EMPTY. main_q and skid_q keep their old values; out_data is don't-care.
  - in_ready=1 on the cycle after flush.
- Reset (rst=0, at any time including mid-transfer):
  - main_v=0, skid_v=0, main_q=0, skid_q=0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1.
  - Deassertion of rst is released synchronously by the surrounding design; the block needs no internal synchronizer.
- in_data is ignored when in_valid=0 or in_ready=0. A held in_valid with in_ready=0 is not a push.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], reset 0.
  - Increments every cycle with out_valid=1 and out_ready=0, and saturates at 16'hFFFF.
  - Cleared by flush.
  - Used for pipeline stall profiling.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Default width constant PIPE_W=32.
  - STALL_CNT_W=16.
- Sub-module: the existing write-enabled N-bit register (REG_N) is reused for main_q and skid_q. Its enable is driven by this block's load logic. Instantiate it with an active-low-reset wrapper or inline flops if REG_N's reset polarity differs.

Test Plan:
1. Reset: rst=0 with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, in_ready=1. After release with out_ready=1, 0xDEADBEEF appears on out_data next cycle.
2. Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles; in_ready stays 1 throughout.
3. Backpressure: out_ready=0, push 0xA then 0xB -> in_ready=0 after the second push. 0xC held on in_data is not accepted. Raising out_ready -> pops 0xA, 0xB, then 0xC is accepted.
4. Flush in TWO (entries 0x5, 0x6) with simultaneous in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming payload is dropped.
5. Async reset mid-transfer: rst asserted off-edge while in TWO -> outputs cleared immediately, without waiting for clk.
6. With PIPE_SKID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10. Flush -> stall_cnt=0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: occupancy encoding and default widths.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int PIPE_W      = 32;
    localparam int STALL_CNT_W = 16;

    // The encoding equals the number of occupied entries.
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_reg_n.sv
// Write-enabled N-bit register with asynchronous active-low clear; holds when en=0.
module reg_n #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid stage register: in_ready and out_data are both registered.
// Optional stall profiling counter is enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int reg_size = PIPE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [reg_size-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [reg_size-1:0] out_data,
    output logic [1:0]          dbg_state
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer keeps valid/data steady until it sees ready, ready never waits on valid.
    skid_state_e         state_q, state_d;
    logic                push, pop;
    logic                main_en, skid_en;
    logic [reg_size-1:0] main_d, main_q, skid_q;

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = (state_q != S_TWO);
    assign out_data  = main_q;
    assign dbg_state = state_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    main_en = 1'b1;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    main_en = 1'b1;
                end else if (push) begin
                    skid_en = 1'b1;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Squash wins over any transfer; payload registers keep stale contents.
        if (flush) begin
            main_en = 1'b0;
            skid_en = 1'b0;
            state_d = S_EMPTY;
        end
    end

    reg_n #(.W(reg_size)) u_main (
        .clk   (clk),
        .rst_n (rst),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    reg_n #(.W(reg_size)) u_skid (
        .clk   (clk),
        .rst_n (rst),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_SKID_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based FIFO model.
// Stall counter checks are active when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   dbg_state;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [W-1:0] exp_q[$];
    int unsigned  exp_stall = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.reg_size(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dbg_state (dbg_state)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
        check("in_ready", W'(in_ready), W'(exp_q.size() < 2));
        check("occupancy", W'(dbg_state), W'(exp_q.size()));
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("stall_cnt", W'(stall_cnt), W'(exp_stall));
`endif
    endtask

    // Applies one cycle of inputs, advances the model, checks after the edge.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] id,
                               input logic ordy, input logic fl);
        bit acc, take;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        acc  = iv && (exp_q.size() < 2);
        take = (exp_q.size() > 0) && ordy;
        if (fl) begin
            exp_q.delete();
            exp_stall = 0;
        end else begin
            if ((exp_q.size() > 0) && !ordy && exp_stall < 16'hFFFF) exp_stall++;
            if (take) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(id);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_valid"}, W'(out_valid), W'(0));
        check({tag, "_data"}, out_data, W'(0));
        check({tag, "_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        // Reset held with an upstream payload present.
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_check("rst");
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("first_data", out_data, 32'hDEAD_BEEF);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Streaming at full rate.
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
            check("stream_data", out_data, W'(i));
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: third payload waits until space frees.
        drive_cycle(1'b1, 32'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hB, 1'b0, 1'b0);
        check("bp_full", W'(in_ready), W'(0));
        drive_cycle(1'b1, 32'hC, 1'b0, 1'b0);
        check("bp_hold", out_data, 32'hA);
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_pop_a", out_data, 32'hB);
        drive_cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_accept_c", out_data, 32'hC);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a competing push.
        drive_cycle(1'b1, 32'h5, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h6, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h7, 1'b0, 1'b1);
        check("flush_valid", W'(out_valid), W'(0));
        check("flush_ready", W'(in_ready), W'(1));
        drive_cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while full, asserted between edges.
        drive_cycle(1'b1, 32'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h22, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        reset_outputs_check("async_rst");
        exp_q.delete();
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), W'($urandom()),
                        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b1);

`ifdef PIPE_SKID_STALL_CNT_EN
        drive_cycle(1'b1, 32'h99, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("stall_10", W'(stall_cnt), W'(10));
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("stall_flush", W'(stall_cnt), W'(0));
        drive_cycle(1'b1, 32'h98, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", W'(stall_cnt), W'(16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
